// File: rtl/rx_frame_controller.sv
// rtl/rx_frame_controller.sv - UART-style receive framer: start, data, even parity, stop, break hold
module rx_frame_controller #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLKS_PER_BIT     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in_synced,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        is_parity_stage,
    output logic                        rx_done,
    output logic                        parity_error,
    output logic                        framing_error,
    output logic                        busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          bit_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic                      pending_parity_error;
    logic                      mid_start;
    logic                      sample_point;
    logic                      parity_strobe;
    logic                      done_strobe;
    logic [INPUT_DATA_WIDTH:0] data_shifted;

    // Start is qualified half a bit in; every later bit is sampled a full period on.
    assign mid_start    = (state == START) && (bit_cnt == CNT_MID);
    assign sample_point = (bit_cnt == CNT_LAST);
    assign data_shifted = {serial_in_synced, received_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!serial_in_synced) begin
                    state_next = START;
                end
            end
            START: begin
                if (mid_start) begin
                    state_next = serial_in_synced ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_point && (bit_idx == IDX_LAST)) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                if (sample_point) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_point) begin
                    state_next = serial_in_synced ? IDLE : BREAK_WAIT;
                end
            end
            BREAK_WAIT: begin
                if (serial_in_synced) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        parity_strobe = 1'b0;
        done_strobe   = 1'b0;
        if (state != IDLE) begin
            busy = 1'b1;
        end
        if ((state == PARITY) && sample_point) begin
            parity_strobe = 1'b1;
        end
        if ((state == STOP) && sample_point) begin
            done_strobe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt              <= '0;
            bit_idx              <= '0;
            received_data        <= '0;
            is_parity_stage      <= 1'b0;
            rx_done              <= 1'b0;
            parity_error         <= 1'b0;
            framing_error        <= 1'b0;
            pending_parity_error <= 1'b0;
        end else begin
            is_parity_stage <= parity_strobe;
            rx_done         <= done_strobe;

            case (state)
                IDLE, BREAK_WAIT: bit_cnt <= '0;
                START:            bit_cnt <= mid_start ? '0 : bit_cnt + CNT_ONE;
                default:          bit_cnt <= sample_point ? '0 : bit_cnt + CNT_ONE;
            endcase

            if (mid_start) begin
                bit_idx <= '0;
            end

            if ((state == DATA) && sample_point) begin
                received_data <= data_shifted[INPUT_DATA_WIDTH:1];
                bit_idx       <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_ONE;
            end

            // Even parity: the parity bit plus all data bits must XOR to zero.
            if (parity_strobe) begin
                pending_parity_error <= serial_in_synced ^ (^received_data);
            end

            // Error flags only move here, so they stay stable between rx_done pulses.
            if (done_strobe) begin
                parity_error  <= pending_parity_error;
                framing_error <= ~serial_in_synced;
            end
        end
    end

endmodule
